pe_array_ctrl: RTL
==================

# pe_array_ctrl

Sequencer for the SYSTOLIC_SIZE×SYSTOLIC_SIZE output-stationary PE array of the YOLO conv engine. For each output tile it clears the PE accumulators, issues `num_k` operand reads to the weight/IFM feeders, and waits for the skewed wavefront to drain. It then shifts the accumulated results out of the array's MAC chain and flags each output column beat to the OFM writer. One tile per `start`; no overlap between tiles.

## Interface
- `DATA_WIDTH`, 16, operand width (passed through for consistency with the array; no datapath here)
- `SYSTOLIC_SIZE`, 16, array dimension S; S ≥ 2
- `K_WIDTH`, 12, width of accumulation length and read address
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that launches a tile; sampled only in IDLE
- `num_k`  in  K_WIDTH  accumulation length; latched on accepted `start`
- `rd_en`  out  1  feeder read strobe (weight and IFM buffers together)
- `rd_addr`  out  K_WIDTH  feeder read address, 0..num_k-1
- `reset_pe`  out  1  clears all PE accumulators
- `write_out_en`  out  1  PE array shift-out enable
- `ofm_valid`  out  1  the array's `ofm_out` holds a valid column beat
- `ofm_col`  out  $clog2(S)  column index of the current beat
- `busy`  out  1  tile in progress
- `done`  out  1  one-cycle pulse on the last OFM beat

## Operation
- All outputs reset to 0. State resets to IDLE.
- FSM states and transitions:
  - IDLE→CLEAR on `start` when `num_k`≠0.
  - IDLE→DONE on `start` when `num_k`=0. No `reset_pe`, no reads, no beats; `done` still pulses.
  - CLEAR (1 cycle) → FEED.
  - FEED (`num_k` cycles) → DRAIN.
  - DRAIN (2·S cycles) → WRITE.
  - WRITE (S cycles) → DONE.
  - DONE (1 cycle) → IDLE.
- CLEAR: `reset_pe`=1.
- FEED:
  - `rd_en`=1.
  - `rd_addr` starts at 0 and increments by 1 each cycle; last value is `num_k`-1.
  - `rd_addr` holds its last value outside FEED.
- DRAIN: covers the 1-cycle buffer read latency, the 2(S-1) skew of the row/column feeders, and 1 MAC register stage.
- WRITE: `write_out_en`=1.
- `ofm_valid` is `write_out_en` delayed by one register.
  - `ofm_col` counts 0..S-1 across the valid beats.
  - Column 0 is emitted first.
  - `ofm_col` returns to 0 when `ofm_valid`=0.
- `busy`=1 in every state except IDLE.
- `done`=1 in DONE only. In a normal tile this coincides with the last `ofm_valid` beat (`ofm_col`=S-1).
- A `start` outside IDLE is ignored. `num_k` changes outside IDLE are ignored.
- A `start` in the cycle `busy` falls is ignored. The earliest new `start` is the first IDLE cycle.
- `rst_n` low mid-tile: immediate return to IDLE with all outputs 0. The PE contents are then undefined; the next tile clears them via CLEAR.
- Counters are sized as follows:
  - Phase counter: max(K_WIDTH, $clog2(2S)+1) bits.
  - `num_k`=2^K_WIDTH−1 must work without wrap.

## Timing
Accepted `start` at cycle 0; N=`num_k`.
- Cycle 1: `reset_pe`.
- Cycles 2..N+1: `rd_en`, addresses 0..N-1.
- Cycles N+2..N+1+2S: DRAIN.
- Cycles N+2+2S..N+1+3S: `write_out_en`.
- Cycles N+3+2S..N+2+3S: `ofm_valid`.
- Cycle N+2+3S: `done`.
- `busy` is high for cycles 1..N+2+3S.
- Total latency from `start` to `done` is N+2+3S cycles.
- Outputs are registered, except `busy`/`done`, which may be state decodes.

## Structure
- Shared package `systolic_pkg` holds:
  - the state enum (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE);
  - `DRAIN_CYCLES = 2*SYSTOLIC_SIZE`;
  - `WRITE_CYCLES = SYSTOLIC_SIZE`.
- One sub-module, `phase_counter`: loadable down-counter with a terminal-count flag. It is reused for the FEED, DRAIN and WRITE lengths.
- The address counter and the `ofm_col` counter stay inline.

## Test plan
- S=16, `num_k`=9, `start` at cycle 0:
  - `reset_pe` at cycle 1 only;
  - `rd_en` at cycles 2–10 with addresses 0–8;
  - `write_out_en` at cycles 43–58;
  - `ofm_valid` at cycles 44–59 with `ofm_col` 0–15;
  - `done` at cycle 59;
  - `busy` at cycles 1–59.
- `num_k`=0: `done` at cycle 1, `busy` at cycle 1 only, no `reset_pe`/`rd_en`/`write_out_en`.
- `start` pulses at cycles 5, 30 and 59 during the N=9 tile → ignored, all waveforms identical to the first scenario. A `start` at cycle 60 launches a second tile whose `reset_pe` falls at cycle 61.
- `rst_n` low at cycle 20 of an N=9 tile → all outputs 0 the same cycle. After release, a new `start` reproduces the first scenario's timing.
- `num_k` changed at cycle 3 from 9 to 100 → the tile still issues exactly 9 reads.
- `num_k`=4095 (K_WIDTH=12) → 4095 reads, `rd_addr` ends at 4094, `done` at cycle 4145.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic PE array sequencer.
// Holds the FSM state enum, phase lengths and counter sizing helper.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int SYSTOLIC_SIZE_DEF = 16;
    localparam int DRAIN_CYCLES      = 2 * SYSTOLIC_SIZE_DEF;
    localparam int WRITE_CYCLES      = SYSTOLIC_SIZE_DEF;

    // Phase counter must hold num_k-1 and 2S-1 without wrapping.
    function automatic int phase_width(input int kw, input int s);
        int dw;
        dw = $clog2(2 * s) + 1;
        return (kw > dw) ? kw : dw;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with terminal-count flag.
// Shared by the FEED, DRAIN and WRITE phases of the sequencer.
module phase_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the output-stationary systolic PE array.
// Clears accumulators, feeds num_k operands, drains, then shifts out.
module pe_array_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
    parameter int K_WIDTH       = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [K_WIDTH-1:0]               num_k,
    output logic                             rd_en,
    output logic [K_WIDTH-1:0]               rd_addr,
    output logic                             reset_pe,
    output logic                             write_out_en,
    output logic                             ofm_valid,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] ofm_col,
    output logic                             busy,
    output logic                             done
);

    localparam int PW = phase_width(K_WIDTH, SYSTOLIC_SIZE);
    localparam int CW = $clog2(SYSTOLIC_SIZE);

    localparam logic [PW-1:0] DRAIN_LOAD = PW'(2 * SYSTOLIC_SIZE - 1);
    localparam logic [PW-1:0] WRITE_LOAD = PW'(SYSTOLIC_SIZE - 1);

    if (SYSTOLIC_SIZE < 2 || DATA_WIDTH < 1) begin : g_param_check
        $error("pe_array_ctrl: SYSTOLIC_SIZE must be >= 2");
    end

    state_t          state;
    logic [K_WIDTH-1:0] k_lat;
    logic            cnt_load;
    logic            cnt_en;
    logic [PW-1:0]   cnt_val;
    logic            cnt_tc;

    phase_counter #(
        .W(PW)
    ) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (cnt_en),
        .tc      (cnt_tc)
    );

    // Phase counter control: reload on each phase entry, count within.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        unique case (state)
            CLEAR: begin
                cnt_load = 1'b1;
                cnt_val  = PW'(k_lat) - PW'(1);
            end
            FEED: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = WRITE_LOAD;
                end
            end
            WRITE: begin
                cnt_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Tile FSM with registered strobes and inline read address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_lat        <= '0;
            reset_pe     <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            write_out_en <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_lat <= num_k;
                        if (num_k != '0) begin
                            state    <= CLEAR;
                            reset_pe <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    state    <= FEED;
                    reset_pe <= 1'b0;
                    rd_en    <= 1'b1;
                    rd_addr  <= '0;
                end
                FEED: begin
                    if (cnt_tc) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + K_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_tc) begin
                        state        <= WRITE;
                        write_out_en <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt_tc) begin
                        state        <= DONE;
                        write_out_en <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output beat flag trails the shift enable; column counts valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofm_valid <= 1'b0;
            ofm_col   <= '0;
        end else begin
            ofm_valid <= write_out_en;
            if (write_out_en && ofm_valid) begin
                ofm_col <= ofm_col + CW'(1);
            end else begin
                ofm_col <= '0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
